// File: rtl/id_ex_decode_stage.sv
// id_ex_decode_stage
//   Decodes the instruction held in IF/ID into the EX control bundle and
//   registers it in the ID/EX pipeline register. Inserts a bubble on a
//   load-use hazard, holds on EX_STALL, clears on FLUSH, flags illegal
//   encodings and counts the illegal instructions it accepts (saturating).
// Ports
//   CLK, RST_N          clock, async active-low reset
//   IF_VALID, IR, PC    instruction from IF/ID
//   ID_READY            IF/ID may advance (combinational)
//   FLUSH, EX_STALL     kill ID instruction / hold ID/EX
//   EX_*                registered control bundle for the execute stage
//   ILL_CNT             saturating count of accepted illegal instructions
module id_ex_decode_stage #(
    parameter int XLEN      = 32,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 CLK,
    input  logic                 RST_N,
    input  logic                 IF_VALID,
    input  logic [31:0]          IR,
    input  logic [XLEN-1:0]      PC,
    output logic                 ID_READY,
    input  logic                 FLUSH,
    input  logic                 EX_STALL,
    output logic                 EX_VALID,
    output logic                 EX_REG_WRITE,
    output logic                 EX_MEM_WE2,
    output logic                 EX_MEM_RDEN2,
    output logic [3:0]           EX_ALU_FUN,
    output logic                 EX_ALU_SRCA,
    output logic [1:0]           EX_ALU_SRCB,
    output logic [1:0]           EX_RF_WR_SEL,
    output logic                 EX_IS_BRANCH,
    output logic                 EX_IS_JAL,
    output logic                 EX_IS_JALR,
    output logic [2:0]           EX_FUNCT3,
    output logic [4:0]           EX_RS1,
    output logic [4:0]           EX_RS2,
    output logic [4:0]           EX_RD,
    output logic [XLEN-1:0]      EX_PC,
    output logic                 EX_ILLEGAL,
    output logic [ILL_CNT_W-1:0] ILL_CNT
);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic            mem_we2;
        logic            mem_rden2;
        logic [3:0]      alu_fun;
        logic            alu_srca;
        logic [1:0]      alu_srcb;
        logic [1:0]      rf_wr_sel;
        logic            is_branch;
        logic            is_jal;
        logic            is_jalr;
        logic [2:0]      funct3;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic [XLEN-1:0] pc;
        logic            illegal;
    } ex_bundle_t;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    assign opc = IR[6:0];
    assign f3  = IR[14:12];
    assign f7  = IR[31:25];

    ex_bundle_t           dec, ex_q;
    logic                 ill, uses_rs1, uses_rs2, hazard;
    logic [ILL_CNT_W-1:0] ill_cnt;

    always_comb begin
        dec        = '0;
        ill        = 1'b0;
        uses_rs1   = 1'b0;
        uses_rs2   = 1'b0;
        dec.valid  = 1'b1;
        dec.funct3 = f3;
        dec.rs1    = IR[19:15];
        dec.rs2    = IR[24:20];
        dec.rd     = IR[11:7];
        dec.pc     = PC;
        case (opc)
            OPC_LUI: begin
                dec.alu_fun   = 4'b1001;
                dec.alu_srca  = 1'b1;
                dec.rf_wr_sel = 2'b11;
                dec.reg_write = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_srca  = 1'b1;
                dec.alu_srcb  = 2'b11;
                dec.rf_wr_sel = 2'b11;
                dec.reg_write = 1'b1;
            end
            OPC_JAL: begin
                dec.reg_write = 1'b1;
                dec.is_jal    = 1'b1;
            end
            OPC_JALR: begin
                dec.reg_write = 1'b1;
                dec.is_jalr   = 1'b1;
                uses_rs1      = 1'b1;
                ill           = (f3 != 3'b000);
            end
            OPC_BRANCH: begin
                dec.is_branch = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                ill           = (f3[2:1] == 2'b01);
            end
            OPC_LOAD: begin
                dec.alu_srcb  = 2'b01;
                dec.rf_wr_sel = 2'b10;
                dec.mem_rden2 = 1'b1;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
                ill           = (f3 == 3'b011) || (f3[2:1] == 2'b11);
            end
            OPC_STORE: begin
                dec.alu_srcb  = 2'b10;
                dec.mem_we2   = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                ill           = (f3 > 3'b010);
            end
            OPC_OPIMM: begin
                // only shifts carry a funct7; IR[30] selects srai over srli
                dec.alu_fun   = {IR[30] & (f3 == 3'b101), f3};
                dec.alu_srcb  = 2'b01;
                dec.rf_wr_sel = 2'b11;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
                ill           = ((f3 == 3'b001) && (f7 != 7'b0000000)) ||
                                ((f3 == 3'b101) && (f7 != 7'b0000000) &&
                                 (f7 != 7'b0100000));
            end
            OPC_OP: begin
                dec.alu_fun   = {IR[30], f3};
                dec.rf_wr_sel = 2'b11;
                dec.reg_write = 1'b1;
                uses_rs1      = 1'b1;
                uses_rs2      = 1'b1;
                // funct7=0100000 only exists for sub and sra
                ill           = !((f7 == 7'b0000000) ||
                                  ((f7 == 7'b0100000) &&
                                   ((f3 == 3'b000) || (f3 == 3'b101))));
            end
            OPC_FENCE, OPC_SYSTEM: ;
            default: ill = 1'b1;
        endcase
        if (IR[1:0] != 2'b11) ill = 1'b1;
        if (ill) begin
            // keep register fields and PC for debug; kill every side effect
            dec.reg_write = 1'b0;
            dec.mem_we2   = 1'b0;
            dec.mem_rden2 = 1'b0;
            dec.alu_fun   = 4'b0000;
            dec.alu_srca  = 1'b0;
            dec.alu_srcb  = 2'b00;
            dec.rf_wr_sel = 2'b00;
            dec.is_branch = 1'b0;
            dec.is_jal    = 1'b0;
            dec.is_jalr   = 1'b0;
            dec.illegal   = 1'b1;
        end
    end

    // Load in EX whose result an ID source needs: one bubble resolves it
    // because the bubble clears EX_VALID.
    assign hazard = ex_q.valid & ex_q.mem_rden2 & (ex_q.rd != 5'd0) & IF_VALID &
                    ((uses_rs1 & (dec.rs1 == ex_q.rd)) |
                     (uses_rs2 & (dec.rs2 == ex_q.rd)));

    assign ID_READY = FLUSH | (~EX_STALL & ~hazard);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            ex_q    <= '0;
            ill_cnt <= '0;
        end else if (FLUSH) begin
            ex_q <= '0;
        end else if (EX_STALL) begin
            ex_q <= ex_q;
        end else if (hazard) begin
            ex_q <= '0;
        end else begin
            ex_q <= IF_VALID ? dec : '0;
            if (IF_VALID && dec.illegal && (ill_cnt != {ILL_CNT_W{1'b1}}))
                ill_cnt <= ill_cnt + ILL_CNT_W'(1);
        end
    end

    assign EX_VALID     = ex_q.valid;
    assign EX_REG_WRITE = ex_q.reg_write;
    assign EX_MEM_WE2   = ex_q.mem_we2;
    assign EX_MEM_RDEN2 = ex_q.mem_rden2;
    assign EX_ALU_FUN   = ex_q.alu_fun;
    assign EX_ALU_SRCA  = ex_q.alu_srca;
    assign EX_ALU_SRCB  = ex_q.alu_srcb;
    assign EX_RF_WR_SEL = ex_q.rf_wr_sel;
    assign EX_IS_BRANCH = ex_q.is_branch;
    assign EX_IS_JAL    = ex_q.is_jal;
    assign EX_IS_JALR   = ex_q.is_jalr;
    assign EX_FUNCT3    = ex_q.funct3;
    assign EX_RS1       = ex_q.rs1;
    assign EX_RS2       = ex_q.rs2;
    assign EX_RD        = ex_q.rd;
    assign EX_PC        = ex_q.pc;
    assign EX_ILLEGAL   = ex_q.illegal;
    assign ILL_CNT      = ill_cnt;

endmodule

// File: tb/tb_id_ex_decode_stage.sv
module tb_id_ex_decode_stage;

    logic        CLK = 1'b0;
    logic        RST_N, IF_VALID, FLUSH, EX_STALL;
    logic [31:0] IR, PC;

    logic        ID_READY, EX_VALID, EX_REG_WRITE, EX_MEM_WE2, EX_MEM_RDEN2;
    logic [3:0]  EX_ALU_FUN;
    logic        EX_ALU_SRCA;
    logic [1:0]  EX_ALU_SRCB, EX_RF_WR_SEL;
    logic        EX_IS_BRANCH, EX_IS_JAL, EX_IS_JALR;
    logic [2:0]  EX_FUNCT3;
    logic [4:0]  EX_RS1, EX_RS2, EX_RD;
    logic [31:0] EX_PC;
    logic        EX_ILLEGAL;
    logic [7:0]  ILL_CNT;

    // narrow-counter instance, same stimulus, used for saturation
    logic        s_rdy, s_vld, s_rw, s_we, s_rd2, s_srca, s_br, s_jal, s_jalr, s_ill;
    logic [3:0]  s_fun;
    logic [1:0]  s_srcb, s_sel;
    logic [2:0]  s_f3;
    logic [4:0]  s_rs1, s_rs2, s_rd;
    logic [31:0] s_pc;
    logic [1:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 CLK = ~CLK;

    id_ex_decode_stage #(.XLEN(32), .ILL_CNT_W(8)) dut (
        .CLK(CLK), .RST_N(RST_N), .IF_VALID(IF_VALID), .IR(IR), .PC(PC),
        .ID_READY(ID_READY), .FLUSH(FLUSH), .EX_STALL(EX_STALL),
        .EX_VALID(EX_VALID), .EX_REG_WRITE(EX_REG_WRITE), .EX_MEM_WE2(EX_MEM_WE2),
        .EX_MEM_RDEN2(EX_MEM_RDEN2), .EX_ALU_FUN(EX_ALU_FUN), .EX_ALU_SRCA(EX_ALU_SRCA),
        .EX_ALU_SRCB(EX_ALU_SRCB), .EX_RF_WR_SEL(EX_RF_WR_SEL), .EX_IS_BRANCH(EX_IS_BRANCH),
        .EX_IS_JAL(EX_IS_JAL), .EX_IS_JALR(EX_IS_JALR), .EX_FUNCT3(EX_FUNCT3),
        .EX_RS1(EX_RS1), .EX_RS2(EX_RS2), .EX_RD(EX_RD), .EX_PC(EX_PC),
        .EX_ILLEGAL(EX_ILLEGAL), .ILL_CNT(ILL_CNT)
    );

    id_ex_decode_stage #(.XLEN(32), .ILL_CNT_W(2)) dut_sat (
        .CLK(CLK), .RST_N(RST_N), .IF_VALID(IF_VALID), .IR(IR), .PC(PC),
        .ID_READY(s_rdy), .FLUSH(FLUSH), .EX_STALL(EX_STALL),
        .EX_VALID(s_vld), .EX_REG_WRITE(s_rw), .EX_MEM_WE2(s_we),
        .EX_MEM_RDEN2(s_rd2), .EX_ALU_FUN(s_fun), .EX_ALU_SRCA(s_srca),
        .EX_ALU_SRCB(s_srcb), .EX_RF_WR_SEL(s_sel), .EX_IS_BRANCH(s_br),
        .EX_IS_JAL(s_jal), .EX_IS_JALR(s_jalr), .EX_FUNCT3(s_f3),
        .EX_RS1(s_rs1), .EX_RS2(s_rs2), .EX_RD(s_rd), .EX_PC(s_pc),
        .EX_ILLEGAL(s_ill), .ILL_CNT(s_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, got, exp);
        end
    endtask

    // advance one edge and settle
    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // check the enables of an instruction sitting in EX
    task automatic chk_ctl(input string tag, input logic [3:0] fun, input logic srca,
                           input logic [1:0] srcb, input logic [1:0] sel, input logic rw,
                           input logic br, input logic jal, input logic jalr);
        chk({tag, ".fun"},  EX_ALU_FUN, fun);
        chk({tag, ".srca"}, EX_ALU_SRCA, srca);
        chk({tag, ".srcb"}, EX_ALU_SRCB, srcb);
        chk({tag, ".sel"},  EX_RF_WR_SEL, sel);
        chk({tag, ".rw"},   EX_REG_WRITE, rw);
        chk({tag, ".br"},   EX_IS_BRANCH, br);
        chk({tag, ".jal"},  EX_IS_JAL, jal);
        chk({tag, ".jalr"}, EX_IS_JALR, jalr);
        chk({tag, ".vld"},  EX_VALID, 1'b1);
        chk({tag, ".ill"},  EX_ILLEGAL, 1'b0);
    endtask

    initial begin
        RST_N = 1'b0; IF_VALID = 1'b1; IR = 32'h00500093; PC = 32'h100;
        FLUSH = 1'b0; EX_STALL = 1'b0;

        // reset
        step(); step();
        chk("rst.vld", EX_VALID, 1'b0);
        chk("rst.rw", EX_REG_WRITE, 1'b0);
        chk("rst.srcb", EX_ALU_SRCB, 2'b00);
        chk("rst.rd", EX_RD, 5'd0);
        chk("rst.pc", EX_PC, 32'h0);
        chk("rst.cnt", ILL_CNT, 8'd0);
        chk("rst.rdy", ID_READY, 1'b1);
        RST_N = 1'b1;
        step();
        chk("addi.vld", EX_VALID, 1'b1);
        chk("addi.rw", EX_REG_WRITE, 1'b1);
        chk("addi.srcb", EX_ALU_SRCB, 2'b01);
        chk("addi.sel", EX_RF_WR_SEL, 2'b11);
        chk("addi.rd", EX_RD, 5'd1);
        chk("addi.pc", EX_PC, 32'h100);

        // load-use: lw x5,0(x1) ; add x6,x5,x2
        IR = 32'h0000A283; PC = 32'h104;
        step();
        chk("lw.rden", EX_MEM_RDEN2, 1'b1);
        chk("lw.sel", EX_RF_WR_SEL, 2'b10);
        chk("lw.rd", EX_RD, 5'd5);
        IR = 32'h00228333; PC = 32'h108;
        #1 chk("lu.rdy0", ID_READY, 1'b0);
        step();
        chk("lu.bubble", EX_VALID, 1'b0);
        chk("lu.bubble_rd", EX_RD, 5'd0);
        chk("lu.rdy1", ID_READY, 1'b1);
        step();
        chk("lu.add_vld", EX_VALID, 1'b1);
        chk("lu.add_rd", EX_RD, 5'd6);
        chk("lu.add_rs1", EX_RS1, 5'd5);
        chk("lu.add_rs2", EX_RS2, 5'd2);

        // lw x0 ; add x6,x0,x2 -> no bubble
        IR = 32'h0000A003; PC = 32'h10C;
        step();
        IR = 32'h00200333; PC = 32'h110;
        #1 chk("lu0.rdy", ID_READY, 1'b1);
        step();
        chk("lu0.vld", EX_VALID, 1'b1);
        chk("lu0.rd", EX_RD, 5'd6);

        // flush with sub in ID
        IR = 32'h402081B3; PC = 32'h114; FLUSH = 1'b1;
        #1 chk("fl.rdy", ID_READY, 1'b1);
        step();
        chk("fl.vld", EX_VALID, 1'b0);
        chk("fl.rw", EX_REG_WRITE, 1'b0);
        FLUSH = 1'b0;
        step();
        chk("sub.fun", EX_ALU_FUN, 4'b1000);
        FLUSH = 1'b1; EX_STALL = 1'b1;
        #1 chk("flst.rdy", ID_READY, 1'b1);
        step();
        chk("flst.vld", EX_VALID, 1'b0);
        chk("flst.fun", EX_ALU_FUN, 4'b0000);
        FLUSH = 1'b0; EX_STALL = 1'b0;

        // stall under sw x2,0(x1)
        IR = 32'h0020A023; PC = 32'h118;
        step();
        chk("sw.we", EX_MEM_WE2, 1'b1);
        EX_STALL = 1'b1; IR = 32'h00500093; PC = 32'h11C;
        for (int i = 0; i < 3; i++) begin
            #1 chk("st.rdy", ID_READY, 1'b0);
            step();
            chk("st.we", EX_MEM_WE2, 1'b1);
            chk("st.srcb", EX_ALU_SRCB, 2'b10);
            chk("st.pc", EX_PC, 32'h118);
            chk("st.rs2", EX_RS2, 5'd2);
        end
        EX_STALL = 1'b0;
        step();
        chk("st.after_pc", EX_PC, 32'h11C);

        // illegals
        IR = 32'h0000007F; PC = 32'h120;
        step();
        chk("il1.ill", EX_ILLEGAL, 1'b1);
        chk("il1.rw", EX_REG_WRITE, 1'b0);
        chk("il1.cnt", ILL_CNT, 8'd1);
        IR = 32'h022081B3; PC = 32'h124;
        step();
        chk("il2.ill", EX_ILLEGAL, 1'b1);
        chk("il2.rw", EX_REG_WRITE, 1'b0);
        chk("il2.fun", EX_ALU_FUN, 4'b0000);
        chk("il2.cnt", ILL_CNT, 8'd2);
        IF_VALID = 1'b0;
        step();
        chk("nv.vld", EX_VALID, 1'b0);
        chk("nv.ill", EX_ILLEGAL, 1'b0);
        chk("nv.cnt", ILL_CNT, 8'd2);
        IF_VALID = 1'b1;

        // decode sweep
        IR = 32'h123452B7; PC = 32'h200; step();
        chk_ctl("lui", 4'b1001, 1'b1, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        IR = 32'h00001297; PC = 32'h204; step();
        chk_ctl("auipc", 4'b0000, 1'b1, 2'b11, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        IR = 32'h008000EF; PC = 32'h208; step();
        chk_ctl("jal", 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b1, 1'b0);
        IR = 32'h000100E7; PC = 32'h20C; step();
        chk_ctl("jalr", 4'b0000, 1'b0, 2'b00, 2'b00, 1'b1, 1'b0, 1'b0, 1'b1);
        chk("jalr.rs1", EX_RS1, 5'd2);
        IR = 32'h00208463; PC = 32'h210; step();
        chk_ctl("beq", 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("beq.f3", EX_FUNCT3, 3'b000);
        IR = 32'h0020F463; PC = 32'h214; step();
        chk_ctl("bgeu", 4'b0000, 1'b0, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0);
        chk("bgeu.f3", EX_FUNCT3, 3'b111);
        chk("bgeu.pc", EX_PC, 32'h214);
        IR = 32'h4030D293; PC = 32'h218; step();
        chk_ctl("srai", 4'b1101, 1'b0, 2'b01, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);
        IR = 32'h4020D2B3; PC = 32'h21C; step();
        chk_ctl("sra", 4'b1101, 1'b0, 2'b00, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0);

        // three more illegals: load f3=011, branch f3=010, jalr f3=001
        IR = 32'h0000B283; step();
        chk("il3.ill", EX_ILLEGAL, 1'b1);
        chk("il3.rden", EX_MEM_RDEN2, 1'b0);
        IR = 32'h0020A463; step();
        chk("il4.br", EX_IS_BRANCH, 1'b0);
        IR = 32'h000110E7; step();
        chk("il5.jalr", EX_IS_JALR, 1'b0);
        chk("il5.cnt", ILL_CNT, 8'd5);
        chk("sat.cnt", s_cnt, 2'd3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_decode_stage.md
# id_ex_decode_stage

Registered instruction-decode stage for the pipelined Otter core: decodes the ID instruction into the EX control bundle and holds it in the ID/EX pipeline register. Extends the combinational control decoder with a valid/ready handshake, load-use hazard bubbles, flush and stall handling, branch/jump decode, illegal-instruction detection, and a saturating illegal-instruction counter. Sits between the IF/ID register and the execute stage.

## Interface
- XLEN, 32, PC width carried through to EX.
- ILL_CNT_W, 8, width of the saturating illegal-instruction counter.
- CLK  in  1  rising-edge clock.
- RST_N  in  1  asynchronous, active-low reset.
- IF_VALID  in  1  IR/PC hold a real instruction.
- IR  in  32  instruction word from IF/ID.
- PC  in  XLEN  address of IR.
- ID_READY  out  1  instruction consumed this cycle (IF/ID may advance).
- FLUSH  in  1  taken branch/jump resolved in EX; kill ID instruction.
- EX_STALL  in  1  downstream busy; hold ID/EX register.
- EX_VALID  out  1  ID/EX register holds a live instruction.
- EX_REG_WRITE, EX_MEM_WE2, EX_MEM_RDEN2  out  1 each  write-back, store and load enables.
- EX_ALU_FUN  out  4  ALU op; EX_ALU_SRCA out 1 (0 rs1, 1 U-imm); EX_ALU_SRCB out 2 (00 rs2, 01 I-imm, 10 S-imm, 11 PC).
- EX_RF_WR_SEL  out  2  00 PC+4, 10 memory, 11 ALU.
- EX_IS_BRANCH, EX_IS_JAL, EX_IS_JALR  out  1 each  control-transfer type.
- EX_FUNCT3  out  3  branch condition / memory size.
- EX_RS1, EX_RS2, EX_RD  out  5 each  register addresses.
- EX_PC  out  XLEN  PC of EX instruction.
- EX_ILLEGAL  out  1  EX instruction is illegal.
- ILL_CNT  out  ILL_CNT_W  illegal instructions accepted since reset.

## Operation
- Decode (combinational, internal): AUIPC SRCA=1, SRCB=11, FUN=0000, SEL=11, REG_WRITE. LUI FUN=1001, SRCA=1, SEL=11, REG_WRITE. JAL/JALR SEL=00, REG_WRITE, IS_JAL/IS_JALR. Load SRCB=01, SEL=10, RDEN2, REG_WRITE. Store SRCB=10, WE2. OP-IMM SRCB=01, SEL=11, REG_WRITE, FUN={IR[30]&(f3==101), f3}. OP FUN={IR[30], f3}, SEL=11, REG_WRITE. Branch IS_BRANCH, FUN=0000. FENCE(0001111)/SYSTEM(1110011): legal, all enables 0.
- Illegal: IR[1:0]!=11; unknown opcode; OP funct7 not 0000000/0100000, or 0100000 with f3 not 000/101; OP-IMM f3=001 with funct7!=0, f3=101 with funct7 not 0000000/0100000; load f3 in {011,110,111}; store f3>010; branch f3 in {010,011}; JALR f3!=000. Illegal: all enables, IS_* = 0, ILLEGAL=1.
- Register use: rs1 used by OP, OP-IMM, load, store, branch, JALR; rs2 by OP, store, branch.
- Hazard = EX_VALID & EX_MEM_RDEN2 & EX_RD!=0 & IF_VALID & ((uses_rs1 & rs1==EX_RD) | (uses_rs2 & rs2==EX_RD)).
- Per-cycle priority:
  - FLUSH: ID/EX cleared (EX_VALID=0, all controls 0); ID_READY=1 (ID instruction discarded).
  - else EX_STALL: ID/EX holds; ID_READY=0.
  - else Hazard: bubble loaded (ID/EX cleared); ID_READY=0.
  - else: ID/EX loads decode of IR/PC, EX_VALID=IF_VALID; ID_READY=1. IF_VALID=0 loads a cleared bundle.
- Cleared bundle: every EX_* output 0, including EX_PC, EX_RS*, EX_RD, EX_ILLEGAL.
- ILL_CNT increments by 1 when a legal-path load occurs with IF_VALID=1 and instruction illegal; saturates at all-ones; never decrements.

## Timing
- Reset (RST_N low, async): all EX_* outputs 0, ILL_CNT 0; ID_READY is combinational and follows the priority rules (1 when FLUSH=0, EX_STALL=0, no hazard).
- Decode latency: 1 cycle, IR presented with ID_READY=1 at edge n appears on EX_* after edge n.
- Load-use: exactly one bubble cycle; EX_VALID=0 after the bubble removes the hazard term, so the dependent instruction is accepted the following cycle.
- ID_READY is combinational from FLUSH, EX_STALL, IR and ID/EX state; no combinational path from IR to any EX_* output.
- FLUSH and EX_STALL together: FLUSH wins. FLUSH during a hazard: flush, no bubble count.
- RST_N deasserted mid-stream: first edge after release behaves as from reset.

## Test plan
- Reset: RST_N=0 with IF_VALID=1, IR=0x00500093 -> all EX_* =0, ILL_CNT=0; release -> next edge EX_VALID=1, EX_REG_WRITE=1, EX_ALU_SRCB=01, EX_RD=1.
- Load-use: lw x5,0(x1) then add x6,x5,x2 -> cycle after lw ID_READY=0, EX_VALID=0 next edge, add in EX one cycle later; same with rd=x0 -> no bubble.
- Flush: FLUSH=1 with sub x3,x1,x2 in ID -> ID_READY=1, EX_VALID=0 next edge; FLUSH+EX_STALL same result.
- Stall: EX_STALL=1 for 3 cycles under sw -> EX_* unchanged (MEM_WE2=1, SRCB=10), ID_READY=0 throughout.
- Illegal: IR=0x0000007F, then OP with funct7=0000001 -> EX_ILLEGAL=1, all enables 0, ILL_CNT=2; with ILL_CNT_W=2 and 5 illegals -> ILL_CNT=3.
- Decode sweep: LUI, AUIPC, JAL, JALR, beq/bgeu, srai (IR[30]=1 -> FUN=1101), sra -> fields match Operation section.
